wb_apb_bridge_sync: RTL

Wishbone classic slave to APB master bridge. Sits directly upstream of the peripheral APB crossbar (I2C, PWM, GPIO, timer, direction control, JTAG).
- Converts each single Wishbone transfer into one APB SETUP/ACCESS transfer.
- Honours PREADY wait states and PSLVERR.
- Returns a registered ack or err, and holds the read data for the Wishbone host.

---
 rtl/wb_apb_bridge_sync.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/wb_apb_bridge_sync.sv
// ---------------------------------------------------------------------------
// wb_apb_bridge_sync
//
// Purpose:
//   Wishbone classic slave to APB master bridge. Each single Wishbone
//   transfer becomes one APB SETUP/ACCESS transfer. PREADY wait states and
//   PSLVERR are honoured. The result comes back as a registered one-cycle
//   ack or err, and the read data is held on wbs_dat_o until the next read.
//
// Optional feature (compile-time macro WB2APB_TIMEOUT_EN):
//   When defined, a 16-bit watchdog counts ACCESS cycles with PREADY low.
//   When it reaches TIMEOUT_CYCLES with PREADY still low, the transfer is
//   aborted. The bridge then reports err together with a timeout_o pulse,
//   and a read returns DEAD_BEEF. When the macro is undefined, no counter
//   is built and timeout_o is constant 0.
//
// Parameters:
//   ADDR_W          address width
//   DATA_W          data width (strobe width DATA_W/8)
//   TIMEOUT_CYCLES  watchdog limit, 1..65535 (only used with the macro)
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   wbs_cyc_i/stb_i/we_i      Wishbone request qualifiers
//   wbs_sel_i/dat_i/adr_i     Wishbone byte selects, write data, address
//   wbs_ack_o/err_o/dat_o     Wishbone response (registered)
//   m_apb_addr/sel/ena/write  APB PADDR/PSEL/PENABLE/PWRITE (registered)
//   m_apb_wdata/pstb          APB PWDATA/PSTRB (registered)
//   m_apb_rdata/rready/slverr APB PRDATA/PREADY/PSLVERR
//   timeout_o                 one-cycle pulse on watchdog abort
// ---------------------------------------------------------------------------
module wb_apb_bridge_sync #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [DATA_W/8-1:0]   wbs_sel_i,
  input  logic [DATA_W-1:0]     wbs_dat_i,
  input  logic [ADDR_W-1:0]     wbs_adr_i,
  output logic                  wbs_ack_o,
  output logic                  wbs_err_o,
  output logic [DATA_W-1:0]     wbs_dat_o,
  output logic [ADDR_W-1:0]     m_apb_addr,
  output logic                  m_apb_sel,
  output logic                  m_apb_ena,
  output logic                  m_apb_write,
  output logic [DATA_W-1:0]     m_apb_wdata,
  output logic [DATA_W/8-1:0]   m_apb_pstb,
  input  logic [DATA_W-1:0]     m_apb_rdata,
  input  logic                  m_apb_rready,
  input  logic                  m_apb_slverr,
  output logic                  timeout_o
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   addr_r,  addr_s;
  logic [DATA_W-1:0]   wdata_r, wdata_s;
  logic                write_r, write_s;
  logic [STRB_W-1:0]   pstb_r,  pstb_s;
  logic                psel_r,  psel_s;
  logic                pena_r,  pena_s;
  logic [DATA_W-1:0]   rdata_r, rdata_s;
  logic                ack_r,   ack_s;
  logic                err_r,   err_s;

`ifdef WB2APB_TIMEOUT_EN
  localparam logic [15:0]       TIMEOUT_LIM  = 16'(TIMEOUT_CYCLES);
  localparam logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(32'hDEAD_BEEF);

  logic [15:0] cnt_r, cnt_s;
  logic        tmo_r, tmo_s;
`else
  // The limit only matters when the watchdog is built; keep it referenced.
  logic [15:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 16'(TIMEOUT_CYCLES);
`endif

  // Next-state and next-register computation for the transfer FSM.
  always_comb begin
    state_s = state_r;
    addr_s  = addr_r;
    wdata_s = wdata_r;
    write_s = write_r;
    pstb_s  = pstb_r;
    psel_s  = psel_r;
    pena_s  = pena_r;
    rdata_s = rdata_r;
    ack_s   = 1'b0;
    err_s   = 1'b0;
`ifdef WB2APB_TIMEOUT_EN
    cnt_s   = cnt_r;
    tmo_s   = 1'b0;
`endif

    case (state_r)
      IDLE: begin
        psel_s = 1'b0;
        pena_s = 1'b0;
        if (wbs_cyc_i && wbs_stb_i) begin
          addr_s  = wbs_adr_i;
          wdata_s = wbs_dat_i;
          write_s = wbs_we_i;
          // Reads never carry byte strobes on APB.
          pstb_s  = wbs_we_i ? wbs_sel_i : {STRB_W{1'b0}};
          psel_s  = 1'b1;
          state_s = SETUP;
        end else begin
          state_s = IDLE;
        end
      end

      SETUP: begin
        psel_s  = 1'b1;
        pena_s  = 1'b1;
        state_s = ACCESS;
`ifdef WB2APB_TIMEOUT_EN
        cnt_s   = 16'd0;
`endif
      end

      ACCESS: begin
        if (m_apb_rready) begin
          state_s = RESP;
          psel_s  = 1'b0;
          pena_s  = 1'b0;
          // PRDATA is captured even on PSLVERR; writes leave it alone.
          if (!write_r) begin
            rdata_s = m_apb_rdata;
          end else begin
            rdata_s = rdata_r;
          end
          // The response register is loaded on the edge entering RESP, so
          // cyc is qualified here; a host that has already left the cycle
          // gets nothing.
          if (wbs_cyc_i) begin
            err_s = m_apb_slverr;
            ack_s = ~m_apb_slverr;
          end else begin
            err_s = 1'b0;
            ack_s = 1'b0;
          end
        end else begin
`ifdef WB2APB_TIMEOUT_EN
          if (cnt_r == TIMEOUT_LIM) begin
            state_s = RESP;
            psel_s  = 1'b0;
            pena_s  = 1'b0;
            tmo_s   = 1'b1;
            if (!write_r) begin
              rdata_s = TIMEOUT_DATA;
            end else begin
              rdata_s = rdata_r;
            end
            if (wbs_cyc_i) begin
              err_s = 1'b1;
            end else begin
              err_s = 1'b0;
            end
          end else begin
            cnt_s = cnt_r + 16'd1;
          end
`else
          state_s = ACCESS;
`endif
        end
      end

      RESP: begin
        psel_s  = 1'b0;
        pena_s  = 1'b0;
        state_s = IDLE;
      end

      default: begin
        psel_s  = 1'b0;
        pena_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r <= IDLE;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
      write_r <= 1'b0;
      pstb_r  <= {STRB_W{1'b0}};
      psel_r  <= 1'b0;
      pena_r  <= 1'b0;
      rdata_r <= {DATA_W{1'b0}};
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      addr_r  <= addr_s;
      wdata_r <= wdata_s;
      write_r <= write_s;
      pstb_r  <= pstb_s;
      psel_r  <= psel_s;
      pena_r  <= pena_s;
      rdata_r <= rdata_s;
      ack_r   <= ack_s;
      err_r   <= err_s;
    end
  end

`ifdef WB2APB_TIMEOUT_EN
  // Watchdog counter and abort pulse registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt_r <= 16'd0;
      tmo_r <= 1'b0;
    end else begin
      cnt_r <= cnt_s;
      tmo_r <= tmo_s;
    end
  end

  assign timeout_o = tmo_r;
`else
  assign timeout_o = 1'b0;
`endif

  assign wbs_ack_o   = ack_r;
  assign wbs_err_o   = err_r;
  assign wbs_dat_o   = rdata_r;
  assign m_apb_addr  = addr_r;
  assign m_apb_sel   = psel_r;
  assign m_apb_ena   = pena_r;
  assign m_apb_write = write_r;
  assign m_apb_wdata = wdata_r;
  assign m_apb_pstb  = pstb_r;

endmodule
